gf_mixcol_seq: RTL and testbench
================================

// Module: gf_mixcol_seq
// PURPOSE
//  Sequencer that time-shares N_MUL GF(2^8) log/exp-table multipliers to compute AES
//  MixColumns (and optionally InvMixColumns) on one 32-bit state column.
//  Sits between the AES round datapath and the UART-fed state buffer.
//  Valid/ready handshakes on both sides; one column in flight.
// PARAMETERS
//  N_MUL   1   parallel multiplier lanes; legal 1,2,4; CALC cycles = 16/N_MUL
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   col_in valid
//  in_ready   out  1   block can accept a column
//  col_in     in   32  column a0..a3; a0 = [31:24], a3 = [7:0]
//  inv_mode   in   1   1 = InvMixColumns; sampled on accept; ignored without INV_MIXCOL_EN
//  out_valid  out  1   col_out valid
//  out_ready  in   1   consumer accepts col_out
//  col_out    out  32  result b0..b3; same byte order as col_in
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, cnt=0, acc=0, col_out=0, out_valid=0, busy=0.
//    in_ready=1 once rst_n deasserts. Reset mid-operation discards the column; no output.
//  - States:
//    IDLE -(in_valid)-> CALC.
//    CALC -(cnt==16/N_MUL-1)-> DONE.
//    DONE -(out_ready & !in_valid)-> IDLE.
//    DONE -(out_ready & in_valid)-> CALC (back-to-back).
//  - in_ready = (state==IDLE) | (state==DONE & out_ready); combinational.
//  - Accept edge: latch col_in and inv_mode; clear acc and cnt.
//  - CALC cycle: each lane L handles k = cnt*N_MUL+L, row=k[3:2], col=k[1:0].
//    acc[row] ^= gfmul(C[row][col], a[col]); cnt++.
//  - C is circulant, row r = rot-right-by-r of {02,03,01,01} (inv: {0e,0b,0d,09}).
//  - Last CALC edge: col_out <= final acc; out_valid=1 in DONE.
//    col_out and out_valid hold stable until out_ready.
//  - Latency: out_valid rises 16/N_MUL+1 edges after the accept edge (N_MUL=1: 17).
//  - gfmul(x,y) = 0 if x==0 or y==0. Otherwise s = LOG[x]+LOG[y] (9 bit);
//    if s>=255 then s-=255; result = EXP[s[7:0]].
//    EXP[255] = 01 so the s==255 wrap is safe.
//  - Handshake rules:
//    - in_valid with in_ready=0 is held off; col_in must stay stable until accepted.
//    - out_ready with out_valid=0 has no effect.
// CONFIGURATION
//  INV_MIXCOL_EN defined: inv_mode selects the inverse coefficient set.
//  INV_MIXCOL_EN undefined: inv_mode port is present but ignored; forward MixColumns
//    only; inverse coefficient constants are not synthesised.
// STRUCTURE
//  Package aes_gf_pkg holds:
//    - LOG_TABLE[256], EXP_TABLE[256] (localparam byte arrays);
//    - MIX_FWD[4], MIX_INV[4] coefficient rows;
//    - typedef enum logic [1:0] {IDLE, CALC, DONE} mixcol_state_t;
//    - typedef logic [7:0] gf_byte_t.
//  Sub-module gf_mul_logexp: combinational, (a,b) -> p, zero-safe.
//    Instantiated N_MUL times via generate.
//  Top holds the FSM, cnt, operand/coefficient muxing, XOR accumulators and output regs.
// TESTING
//  1. FIPS vector: col_in=db135345 -> col_out=8e4da1bc.
//     N_MUL=1: out_valid exactly 17 edges after accept.
//  2. col_in=f20a225c -> 9fdc589d; col_in=00000000 -> 00000000 (zero path);
//     col_in=01010101 -> 01010101.
//  3. INV_MIXCOL_EN, inv_mode=1: 8e4da1bc -> db135345.
//     Without the macro, same stimulus with inv_mode=1 -> forward result.
//  4. Backpressure: out_ready=0 for 10 cycles after out_valid.
//     col_out stable, in_ready=0; a new column offered then is accepted only on the out_ready edge.
//  5. Back-to-back: in_valid and out_ready held high.
//     Columns db135345 and f20a225c yield both results in order, with no IDLE cycle between.
//  6. Reset: assert rst_n=0 at CALC cnt=5.
//     All outputs 0 immediately (async); after release in_ready=1, and no stale out_valid appears.
//  Run tests 1, 2, 4 and 5 for N_MUL = 1, 2 and 4; check latency = 16/N_MUL+1.

Source files
------------

// File: rtl/aes_gf_pkg.sv
// aes_gf_pkg: shared GF(2^8) definitions for the MixColumns sequencer.
//   - gf_byte_t / gf_table_t    : byte and 256-entry byte-table types
//   - mixcol_state_t            : sequencer states IDLE, CALC, DONE
//   - EXP_TABLE / LOG_TABLE     : antilog/log tables for generator 0x03,
//                                 modulus x^8+x^4+x^3+x+1 (0x11b)
//   - MIX_FWD / MIX_INV         : first coefficient row of the circulant matrix;
//                                 MIX_INV exists only with INV_MIXCOL_EN defined.
// The tables are built by constant functions at elaboration time, which keeps
// them correct by construction instead of relying on 512 transcribed literals.
package aes_gf_pkg;

  typedef logic [7:0]          gf_byte_t;
  typedef logic [255:0][7:0]   gf_table_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mixcol_state_t;

  // Multiply by x (0x02) modulo 0x11b.
  function automatic gf_byte_t xtime(input gf_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // EXP[i] = 03^i for i = 0..254. EXP[255] = 01, so an unreduced sum of 255 is harmless.
  function automatic gf_table_t gen_exp();
    gf_table_t t;
    gf_byte_t  x;
    t = '0;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      t[i[7:0]] = x;
      x = x ^ xtime(x);
    end
    t[8'd255] = 8'h01;
    return t;
  endfunction

  // LOG is the inverse of EXP over the nonzero bytes. LOG[0] is never used.
  function automatic gf_table_t gen_log(input gf_table_t e);
    gf_table_t t;
    t = '0;
    for (int i = 0; i < 255; i++) begin
      t[e[i[7:0]]] = i[7:0];
    end
    return t;
  endfunction

  localparam gf_table_t EXP_TABLE = gen_exp();
  localparam gf_table_t LOG_TABLE = gen_log(EXP_TABLE);

  // Row r of the matrix is this row rotated right by r: C[r][c] = MIX[(c - r) mod 4].
  localparam gf_byte_t MIX_FWD [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
`ifdef INV_MIXCOL_EN
  localparam gf_byte_t MIX_INV [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
`endif

endpackage

// File: rtl/gf_mul_logexp.sv
// gf_mul_logexp: combinational GF(2^8) multiplier built from log/exp tables.
//   i_a, i_b : operands
//   o_p      : product. It is 0 when either operand is 0.
module gf_mul_logexp
  import aes_gf_pkg::*;
(
  input  gf_byte_t i_a,
  input  gf_byte_t i_b,
  output gf_byte_t o_p
);

  logic [8:0] w_sum;
  logic [8:0] w_idx;

  // Log-domain add with a single modular reduction. The maximum sum is 508, so one subtraction of 255 is enough.
  always_comb begin
    w_sum = {1'b0, LOG_TABLE[i_a]} + {1'b0, LOG_TABLE[i_b]};
    if (w_sum >= 9'd255) begin
      w_idx = w_sum - 9'd255;
    end else begin
      w_idx = w_sum;
    end
    if ((i_a == 8'h00) || (i_b == 8'h00)) begin
      o_p = 8'h00;
    end else begin
      o_p = EXP_TABLE[w_idx[7:0]];
    end
  end

endmodule

// File: rtl/gf_mixcol_seq.sv
// gf_mixcol_seq: computes AES MixColumns on one 32-bit column. When INV_MIXCOL_EN is
// defined it can also compute InvMixColumns. N_MUL log/exp multipliers are
// time-shared across the 16 matrix products, so CALC lasts 16/N_MUL cycles.
// One column is in flight at a time.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : input handshake for col_in (a0 = [31:24])
//   inv_mode             : 1 selects the inverse matrix. It is sampled on accept and
//                          ignored unless INV_MIXCOL_EN is defined.
//   out_valid / out_ready: output handshake for col_out (same byte order)
//   busy                 : sequencer is not IDLE
// Parameter N_MUL: 1, 2 or 4 multiplier lanes.
module gf_mixcol_seq
  import aes_gf_pkg::*;
#(
  parameter int N_MUL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] col_in,
  input  logic        inv_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] col_out,
  output logic        busy
);

  localparam logic [3:0] LAST_CNT = 4'(16 / N_MUL - 1);

  mixcol_state_t r_state;
  logic [3:0]    r_cnt;
  gf_byte_t      r_a   [4];
  gf_byte_t      r_acc [4];
  logic [31:0]   r_col_out;
  logic          r_out_valid;
  logic          r_busy;
`ifdef INV_MIXCOL_EN
  logic          r_inv;
`else
  logic          w_unused_inv;
  assign w_unused_inv = inv_mode;
`endif

  logic          w_accept;
  logic [3:0]    w_k    [N_MUL];
  logic [1:0]    w_row  [N_MUL];
  gf_byte_t      w_coef [N_MUL];
  gf_byte_t      w_prod [N_MUL];
  gf_byte_t      w_acc_nxt [4];

  // Input is also accepted in DONE when the result leaves on the same edge. This allows back-to-back columns.
  assign in_ready  = rst_n & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign col_out   = r_col_out;
  assign busy      = r_busy;

  genvar l;
  generate
    for (l = 0; l < N_MUL; l++) begin : g_lane
      logic [1:0] w_cidx;
      assign w_k[l]   = r_cnt * 4'(N_MUL) + 4'(l);
      assign w_row[l] = w_k[l][3:2];
      // Circulant matrix: the coefficient index is (col - row) mod 4.
      assign w_cidx   = w_k[l][1:0] - w_k[l][3:2];
`ifdef INV_MIXCOL_EN
      assign w_coef[l] = r_inv ? MIX_INV[w_cidx] : MIX_FWD[w_cidx];
`else
      assign w_coef[l] = MIX_FWD[w_cidx];
`endif
      gf_mul_logexp u_mul (
        .i_a (w_coef[l]),
        .i_b (r_a[w_k[l][1:0]]),
        .o_p (w_prod[l])
      );
    end
  endgenerate

  // Fold this cycle's lane products into the row accumulators. Lanes may share a row.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      w_acc_nxt[r] = r_acc[r];
    end
    for (int i = 0; i < N_MUL; i++) begin
      w_acc_nxt[w_row[i]] = w_acc_nxt[w_row[i]] ^ w_prod[i];
    end
  end

  // Sequencer FSM with counter, operand latch, accumulators and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_col_out   <= 32'd0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef INV_MIXCOL_EN
      r_inv       <= 1'b0;
`endif
      for (int r = 0; r < 4; r++) begin
        r_a[r]   <= 8'h00;
        r_acc[r] <= 8'h00;
      end
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (r_state == DONE && out_ready) begin
            r_out_valid <= 1'b0;
          end
          if (w_accept) begin
            r_a[0] <= col_in[31:24];
            r_a[1] <= col_in[23:16];
            r_a[2] <= col_in[15:8];
            r_a[3] <= col_in[7:0];
`ifdef INV_MIXCOL_EN
            r_inv  <= inv_mode;
`endif
            for (int r = 0; r < 4; r++) begin
              r_acc[r] <= 8'h00;
            end
            r_cnt   <= 4'd0;
            r_state <= CALC;
            r_busy  <= 1'b1;
          end else if (r_state == DONE && out_ready) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        CALC: begin
          for (int r = 0; r < 4; r++) begin
            r_acc[r] <= w_acc_nxt[r];
          end
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST_CNT) begin
            r_col_out   <= {w_acc_nxt[0], w_acc_nxt[1], w_acc_nxt[2], w_acc_nxt[3]};
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mixcol_seq.sv
// tb_gf_mixcol_seq: bench for gf_mixcol_seq with N_MUL = 1, 2 and 4, using one
// instance per lane count. Expected columns are pushed when a column is offered.
// A monitor pops and compares each column that the DUT hands off.
// Build with INV_MIXCOL_EN to exercise the inverse matrix.
module tb_gf_mixcol_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        inv_mode  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        busy      [3];
  logic [31:0] col_in    [3];
  logic [31:0] col_out   [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      gf_mixcol_seq #(.N_MUL(1 << g)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .col_in    (col_in[g]),
        .inv_mode  (inv_mode[g]),
        .out_valid (out_valid[g]),
        .out_ready (out_ready[g]),
        .col_out   (col_out[g]),
        .busy      (busy[g])
      );
    end
  endgenerate

  // Monitor: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst_n && out_valid[i] && out_ready[i]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected dut%0d got %h required none", i, col_out[i]);
        end else begin
          e = exp_q.pop_front();
          if (e.idx != i || e.data !== col_out[i]) begin
            errors++;
            $display("FAIL out_data dut%0d got %h required %h from dut%0d", i, col_out[i], e.data, e.idx);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic push_exp(input int idx, input logic [31:0] v);
    exp_t e;
    e.idx  = idx;
    e.data = v;
    exp_q.push_back(e);
  endtask

  // Offer a column and return once it has been accepted. acc_cyc is the accept edge.
  task automatic send(input int idx, input logic [31:0] col, input logic inv,
                      input logic [31:0] expv, input bit push, output int acc_cyc);
    int n;
    if (push) push_exp(idx, expv);
    in_valid[idx] = 1'b1;
    col_in[idx]   = col;
    inv_mode[idx] = inv;
    n = 0;
    @(negedge clk);
    while (!in_ready[idx] && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready[idx]) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc       = cyc;
    in_valid[idx] = 1'b0;
  endtask

  // Wait for out_valid at a negedge and return the cycle index of the rising edge.
  task automatic wait_out(input int idx, output int seen);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid[idx] && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid[idx]) chk("out_timeout", 32'd0, 32'd1);
    seen = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_lane(input int idx);
    int a, s, lat;
    bit idle_seen;
    logic [31:0] vin  [5];
    logic [31:0] vexp [5];
    vin  = '{32'hf20a225c, 32'h00000000, 32'h01010101, 32'hd4d4d4d4, 32'h2d26314c};
    vexp = '{32'h9fdc589d, 32'h00000000, 32'h01010101, 32'hd4d4d4d4, 32'h4d7ebdf8};
    lat = 16 / (1 << idx) + 1;

    // FIPS vector and latency. The accept edge counts as edge 1.
    out_ready[idx] = 1'b1;
    send(idx, 32'hdb135345, 1'b0, 32'h8e4da1bc, 1'b1, a);
    wait_out(idx, s);
    chk($sformatf("latency_n%0d", 1 << idx), 32'(s - a + 1), 32'(lat));
    drain();

    // Directed vectors, including the zero-operand path.
    for (int i = 0; i < 5; i++) begin
      send(idx, vin[i], 1'b0, vexp[i], 1'b1, a);
    end
    drain();

    // Backpressure: the result holds while a second column waits.
    out_ready[idx] = 1'b0;
    send(idx, 32'hdb135345, 1'b0, 32'h8e4da1bc, 1'b1, a);
    wait_out(idx, s);
    push_exp(idx, 32'h9fdc589d);
    in_valid[idx] = 1'b1;
    col_in[idx]   = 32'hf20a225c;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_col_hold", col_out[idx], 32'h8e4da1bc);
      chk("bp_in_ready", 32'(in_ready[idx]), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready[idx] = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_release", 32'(in_ready[idx]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[idx] = 1'b0;
    @(negedge clk);
    chk("bp_accepted_busy", 32'(busy[idx]), 32'd1);
    chk("bp_accepted_ovalid", 32'(out_valid[idx]), 32'd0);
    drain();

    // Back-to-back: in_valid and out_ready both stay high.
    push_exp(idx, 32'h8e4da1bc);
    push_exp(idx, 32'h9fdc589d);
    send(idx, 32'hdb135345, 1'b0, 32'h0, 1'b0, a);
    idle_seen = 1'b0;
    in_valid[idx] = 1'b1;
    col_in[idx]   = 32'hf20a225c;
    send(idx, 32'hf20a225c, 1'b0, 32'h0, 1'b0, a);
    @(negedge clk);
    if (!busy[idx]) idle_seen = 1'b1;
    chk("b2b_no_idle", 32'(idle_seen), 32'd0);
    drain();
  endtask

  initial begin
    int a, s;
    bit stale;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      inv_mode[i]  = 1'b0;
      out_ready[i] = 1'b1;
      col_in[i]    = 32'd0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ovalid%0d", i), 32'(out_valid[i]), 32'd0);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_col%0d", i), col_out[i], 32'd0);
      chk($sformatf("rst_iready%0d", i), 32'(in_ready[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("post_rst_iready%0d", i), 32'(in_ready[i]), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) run_lane(i);

    // Inverse mode, or the forward result when the inverse matrix is not built.
`ifdef INV_MIXCOL_EN
    send(0, 32'h8e4da1bc, 1'b1, 32'hdb135345, 1'b1, a);
    send(0, 32'h4d7ebdf8, 1'b1, 32'h2d26314c, 1'b1, a);
`else
    send(0, 32'h8e4da1bc, 1'b1, 32'hcd504506, 1'b1, a);
`endif
    send(0, 32'h8e4da1bc, 1'b0, 32'hcd504506, 1'b1, a);
    drain();

    // Asynchronous reset during CALC with cnt == 5.
    send(0, 32'hdb135345, 1'b0, 32'h0, 1'b0, a);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ovalid", 32'(out_valid[0]), 32'd0);
    chk("arst_busy", 32'(busy[0]), 32'd0);
    chk("arst_iready", 32'(in_ready[0]), 32'd0);
    chk("arst_col", col_out[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_release_iready", 32'(in_ready[0]), 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid[0] || busy[0]) stale = 1'b1;
    end
    chk("arst_no_stale", 32'(stale), 32'd0);
    s = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
